// File: rtl/mips_muldiv_unit_if.sv
// Execute-stage interface of the multiply/divide unit: launch controls, HI/LO writes and status.
interface mips_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             startE;
    logic [1:0]       opE;
    logic [WIDTH-1:0] srcAE;
    logic [WIDTH-1:0] srcBE;
    logic             abortE;
    logic             mthiE;
    logic             mtloE;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output startE, opE, srcAE, srcBE, abortE, mthiE, mtloE,
        input  busy, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcAE, srcBE, abortE, mthiE, mtloE,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// Signed operations run on magnitudes; the sign is restored in the FIX cycle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input logic                clk,
    input logic                reset,
    mips_muldiv_unit_if.slave  muldiv_io
);
    localparam int unsigned MulCycles = WIDTH / MUL_STEP;
    localparam int unsigned CntW      = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e                 state_q, state_d;
    logic                   is_div_q, is_div_d;
    logic [WIDTH-1:0]       opa_q, opa_d;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     acc_q, acc_d;      // {partial/remainder, multiplier/quotient}
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   neg_lo_q, neg_lo_d; // negate product / quotient
    logic                   neg_hi_q, neg_hi_d; // negate remainder
    logic                   dvz_q, dvz_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [WIDTH+MUL_STEP-1:0] mul_part, mul_sum;
    logic [WIDTH:0]         div_trial, div_diff;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       quo, rem;

    // Operand conditioning and per-step datapath arithmetic.
    assign signed_op = ~muldiv_io.opE[0];
    assign sign_a    = signed_op & muldiv_io.srcAE[WIDTH-1];
    assign sign_b    = signed_op & muldiv_io.srcBE[WIDTH-1];
    assign mag_a     = sign_a ? -muldiv_io.srcAE : muldiv_io.srcAE;
    assign mag_b     = sign_b ? -muldiv_io.srcBE : muldiv_io.srcBE;

    assign mul_part  = {{MUL_STEP{1'b0}}, opa_q} * {{WIDTH{1'b0}}, acc_q[MUL_STEP-1:0]};
    assign mul_sum   = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mul_part;

    // Shifted partial remainder with the next dividend bit appended.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, opa_q};

    assign prod      = neg_lo_q ? -acc_q : acc_q;
    assign quo       = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem       = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        opa_d    = opa_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dvz_d    = dvz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (muldiv_io.mthiE) hi_d = muldiv_io.srcAE;
                if (muldiv_io.mtloE) lo_d = muldiv_io.srcAE;
                if (muldiv_io.startE && !muldiv_io.abortE) begin
                    neg_lo_d = sign_a ^ sign_b;
                    if (muldiv_io.opE[1]) begin
                        is_div_d = 1'b1;
                        opa_d    = mag_b;
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        neg_hi_d = sign_a;
                        dvz_d    = (muldiv_io.srcBE == '0);
                        cnt_d    = CntW'(WIDTH - 1);
                        state_d  = StDiv;
                    end else begin
                        is_div_d = 1'b0;
                        opa_d    = mag_a;
                        acc_d    = {{WIDTH{1'b0}}, mag_b};
                        neg_hi_d = 1'b0;
                        dvz_d    = 1'b0;
                        cnt_d    = CntW'(MulCycles - 1);
                        state_d  = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:MUL_STEP]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StDiv: begin
                if (div_diff[WIDTH]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    // Remainder path already reproduces srcAE when dividing by zero.
                    lo_d = dvz_q ? '1 : quo;
                    hi_d = rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A flush discards the operation, including a pending FIX write.
        if (state_q != StIdle && muldiv_io.abortE) begin
            state_d = StIdle;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            opa_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dvz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dvz_q    <= dvz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign muldiv_io.busy = (state_q != StIdle);
    assign muldiv_io.done = done_q;
    assign muldiv_io.hi   = hi_q;
    assign muldiv_io.lo   = lo_q;
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with a HI/LO register pair for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU as multi-cycle operations launched from the Execute stage and exposes a busy flag to the hazard logic. It also holds the architectural HI/LO state for MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, operand width and HI/LO width in bits (>= 8, even).
MUL_STEP, 1, multiplier bits retired per cycle; allowed values 1, 2, 4; WIDTH % MUL_STEP == 0.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
startE  input  1  launch request, sampled only in IDLE
opE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcAE  input  WIDTH  multiplicand / dividend
srcBE  input  WIDTH  multiplier / divisor
abortE  input  1  cancel in-flight operation (pipeline flush)
mthiE  input  1  write srcAE to HI
mtloE  input  1  write srcAE to LO
busy  output  1  operation in flight; hazard unit stalls on HI/LO access or a new start
done  output  1  one-cycle pulse: HI/LO just updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset low, any time, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, all datapath registers cleared; an in-flight operation is discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE: startE=1 latches opE, srcAE, srcBE; for signed ops, stores operand magnitudes and result sign flags; next state MUL (op 00/01) or DIV (10/11). busy=1 from the following cycle.
- MUL: shift-add, MUL_STEP multiplier bits per cycle into a 2*WIDTH accumulator; WIDTH/MUL_STEP cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle; WIDTH cycles, then FIX.
- FIX: applies sign correction and writes HI/LO at the end of this cycle; next IDLE.
- Latency: with start at edge 0, busy is high for N+1 cycles (N = WIDTH/MUL_STEP or WIDTH); in the next cycle busy=0, done=1 and hi/lo show the new result. WIDTH=32, MUL_STEP=1: busy for 33 cycles.
- Results: MULT/MULTU: {hi,lo} = full 2*WIDTH product (two's complement for MULT). DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (any sign): lo = all ones, hi = srcAE unmodified; normal latency.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- startE while busy: ignored. The hazard unit must stall; the block does not queue.
- abortE while busy: return to IDLE next cycle; hi/lo unchanged; no done. abortE in IDLE has no effect. Same-cycle abortE and startE in IDLE: start is not accepted.
- mthiE/mtloE: write in IDLE only; ignored while busy. Same-cycle MTHI/MTLO and startE in IDLE: the write takes effect; the later operation result overwrites it.
- done is never asserted together with busy.
- hi/lo hold their value except on an MTHI/MTLO write, FIX completion, or reset.

Test Plan:
- WIDTH=32: MULT srcA=7, srcB=0xFFFFFFFD (-3) -> after 33 busy cycles, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with MUL_STEP=4 -> same result, busy for 9 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, done after 33 busy cycles.
- MTLO 0xAA in IDLE, then start MULTU 3*5; assert abortE at busy cycle 10 -> busy drops next cycle, no done, lo=0xAA. startE and MTHI pulses while busy -> ignored.
- Pull reset low mid-DIV (cycle 15) -> busy, done, hi, lo = 0 immediately. Release and start MULT 2*3 -> hi=0, lo=6.
